hit_judge: RTL and testbench

HIT_JUDGE -- requirements
Module: hit_judge

---
 rtl/dance_pkg.sv | 8 +
 rtl/lane_judge.sv | 57 +++++
 rtl/hit_judge.sv | 61 ++++++
 tb/tb_hit_judge.sv | 136 +++++++++++++
 4 files changed

// File: rtl/dance_pkg.sv
// dance_pkg: shared rhythm-game constants and the per-lane judging state type.
package dance_pkg;
  localparam int unsigned LANES = 4;
  localparam int unsigned WINDOW_CYCLES = 12_500_000;
  localparam int unsigned MULT_STEP = 10;
  localparam int unsigned MULT_MAX = 4;
  typedef enum logic {IDLE, WINDOW} lane_state_e;
endpackage

// File: rtl/lane_judge.sv
// lane_judge: one lane's hit window; registers a one-cycle hit or miss pulse
// the cycle after the note is judged.
module lane_judge #(
  parameter int unsigned WINDOW_CYCLES = dance_pkg::WINDOW_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic game_active_i,
  input  logic clear_i,
  input  logic note_valid_i,
  input  logic btn_i,
  output logic hit_o,
  output logic miss_o
);
  import dance_pkg::*;
  localparam int unsigned CW = $clog2(WINDOW_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(WINDOW_CYCLES - 1);
  lane_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic btn_q, hit_d, miss_d, rise, expired;
  assign rise = btn_i & ~btn_q;
  assign expired = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hit_d = 1'b0;
    miss_d = 1'b0;
    if (!game_active_i) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (state_q == IDLE) begin
      state_d = note_valid_i ? WINDOW : IDLE;
      cnt_d = note_valid_i ? LOAD : cnt_q;
    end else begin
      // A press always wins; a fresh note retires the old one and restarts the window.
      hit_d = rise;
      miss_d = !rise && (note_valid_i || expired);
      state_d = (!note_valid_i && (rise || expired)) ? IDLE : WINDOW;
      cnt_d = note_valid_i ? LOAD : (rise || expired) ? '0 : cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      btn_q <= 1'b0;
      hit_o <= 1'b0;
      miss_o <= 1'b0;
    end else begin
      btn_q <= btn_i;
      state_q <= clear_i ? IDLE : state_d;
      cnt_q <= clear_i ? '0 : cnt_d;
      hit_o <= !clear_i && hit_d;
      miss_o <= !clear_i && miss_d;
    end
  end
endmodule

// File: rtl/hit_judge.sv
// hit_judge: per-lane judges plus streak, multiplier, score and best-streak
// aggregation; the streak register itself lives outside and is fed back.
module hit_judge #(
  parameter int unsigned LANES = dance_pkg::LANES,
  parameter int unsigned WINDOW_CYCLES = dance_pkg::WINDOW_CYCLES,
  parameter int unsigned MULT_STEP = dance_pkg::MULT_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             game_active,
  input  logic             clear,
  input  logic [LANES-1:0] note_valid,
  input  logic [LANES-1:0] btn,
  input  logic [31:0]      streak_in,
  output logic [31:0]      streak_next,
  output logic [LANES-1:0] hit_pulse,
  output logic [LANES-1:0] miss_pulse,
  output logic [31:0]      score,
  output logic [31:0]      max_streak,
  output logic [2:0]       multiplier
);
  import dance_pkg::*;
  logic [31:0] pop, step_q, score_d, max_d;
  logic [32:0] streak_sum;
  logic [35:0] score_sum;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_judge #(.WINDOW_CYCLES(WINDOW_CYCLES)) u_lane (
      .clk(clk),
      .reset(reset),
      .game_active_i(game_active),
      .clear_i(clear),
      .note_valid_i(note_valid[g]),
      .btn_i(btn[g]),
      .hit_o(hit_pulse[g]),
      .miss_o(miss_pulse[g])
    );
  end
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop += 32'(hit_pulse[i]);
    step_q = streak_in / 32'(MULT_STEP);
    multiplier = (step_q >= 32'(MULT_MAX - 1)) ? 3'(MULT_MAX) : step_q[2:0] + 3'd1;
    streak_sum = 33'(streak_in) + 33'(pop);
    streak_next = |miss_pulse ? '0 : streak_sum[32] ? '1 : streak_sum[31:0];
    score_sum = 36'(score) + 36'(pop) * 36'(multiplier);
    score_d = |score_sum[35:32] ? '1 : score_sum[31:0];
    max_d = streak_next > max_streak ? streak_next : max_streak;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score <= '0;
      max_streak <= '0;
    end else if (clear) begin
      score <= '0;
      max_streak <= '0;
    end else begin
      score <= |hit_pulse ? score_d : score;
      max_streak <= max_d;
    end
  end
endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed vectors for hit_judge with an 8-cycle window.
module tb_hit_judge;
  logic clk = 1'b0, reset = 1'b1, game_active = 1'b0, clear = 1'b0;
  logic [3:0] note_valid = '0, btn = '0, hit_pulse, miss_pulse;
  logic [31:0] streak_in = '0, streak_next, score, max_streak;
  logic [2:0] multiplier;
  int n_chk = 0, n_fail = 0;
  hit_judge #(.LANES(4), .WINDOW_CYCLES(8), .MULT_STEP(10)) dut (
    .clk(clk), .reset(reset), .game_active(game_active), .clear(clear),
    .note_valid(note_valid), .btn(btn), .streak_in(streak_in),
    .streak_next(streak_next), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .score(score), .max_streak(max_streak), .multiplier(multiplier)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) tick;
    check("rst_hit", 32'(hit_pulse), 0);
    check("rst_miss", 32'(miss_pulse), 0);
    check("rst_score", score, 0);
    check("rst_max", max_streak, 0);
    reset = 1'b0;
    game_active = 1'b1;
    tick;
    // single hit on lane 0, press three cycles after the note
    note_valid = 4'b0001; tick;
    note_valid = '0; repeat (2) tick;
    btn = 4'b0001; streak_in = 5; tick;
    check("t1_hit", 32'(hit_pulse), 32'h1);
    check("t1_streak", streak_next, 6);
    check("t1_mult", 32'(multiplier), 1);
    tick;
    check("t1_hit_off", 32'(hit_pulse), 0);
    check("t1_score", score, 1);
    check("t1_max", max_streak, 6);
    // press on an idle lane is ignored
    btn = 4'b0011; tick; tick;
    check("idle_hit", 32'(hit_pulse), 0);
    check("idle_miss", 32'(miss_pulse), 0);
    btn = '0; tick;
    // lane 2 expires unpressed
    streak_in = 17; note_valid = 4'b0100; tick;
    note_valid = '0; repeat (7) tick;
    check("t2_early", 32'(miss_pulse), 0);
    tick;
    check("t2_miss", 32'(miss_pulse), 32'h4);
    check("t2_streak", streak_next, 0);
    tick;
    check("t2_miss_off", 32'(miss_pulse), 0);
    check("t2_max", max_streak, 17);
    // two lanes hit together at multiplier 3
    note_valid = 4'b0011; tick;
    note_valid = '0; tick;
    btn = 4'b0011; streak_in = 29; tick;
    check("t3_hit", 32'(hit_pulse), 32'h3);
    check("t3_streak", streak_next, 31);
    check("t3_mult", 32'(multiplier), 3);
    tick;
    check("t3_score", score, 7);
    check("t3_max", max_streak, 31);
    btn = '0; tick;
    // press exactly at expiry on lane 0 while lane 3 expires unpressed
    note_valid = 4'b1001; tick;
    note_valid = '0; repeat (7) tick;
    btn = 4'b0001; streak_in = 31; tick;
    check("t4_hit", 32'(hit_pulse), 32'h1);
    check("t4_miss", 32'(miss_pulse), 32'h8);
    check("t4_streak", streak_next, 0);
    tick;
    check("t4_score", score, 11);
    btn = '0; streak_in = 0; tick;
    // renote mid-window: miss for the old note, then hit in the new window
    note_valid = 4'b0010; tick;
    note_valid = '0; repeat (2) tick;
    note_valid = 4'b0010; tick;
    check("t5_miss", 32'(miss_pulse), 32'h2);
    check("t5_nohit", 32'(hit_pulse), 0);
    note_valid = '0; repeat (2) tick;
    btn = 4'b0010; tick;
    check("t5_hit", 32'(hit_pulse), 32'h2);
    tick;
    check("t5_score", score, 12);
    btn = '0; tick;
    // streak saturation
    note_valid = 4'b0100; tick;
    note_valid = '0; btn = 4'b0100; streak_in = 32'hFFFF_FFFF; tick;
    check("t6_sat", streak_next, 32'hFFFF_FFFF);
    check("t6_mult", 32'(multiplier), 4);
    tick;
    check("t6_score", score, 16);
    btn = '0; streak_in = 0; tick;
    // game inactive discards a pending note
    note_valid = 4'b0100; tick;
    note_valid = '0; game_active = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("t7_quiet", 32'(miss_pulse | hit_pulse), 0);
    end
    check("t7_score", score, 16);
    game_active = 1'b1; tick;
    // reset mid-window
    note_valid = 4'b0001; tick;
    note_valid = '0; repeat (3) tick;
    reset = 1'b1; #1;
    check("t8_score", score, 0);
    check("t8_max", max_streak, 0);
    tick;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("t8_quiet", 32'(miss_pulse | hit_pulse), 0);
    end
    // clear wipes score and best streak
    note_valid = 4'b0001; tick;
    note_valid = '0; btn = 4'b0001; tick;
    tick;
    check("t9_score", score, 1);
    check("t9_max", max_streak, 1);
    btn = '0; clear = 1'b1; tick;
    clear = 1'b0;
    check("t9_clr_score", score, 0);
    check("t9_clr_max", max_streak, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
